// File: rtl/regfile_dump_if.sv
// Bundle of the dumper's control inputs, register-file read port and output beat stream.
// The dumper connects through the slave modport; the driving side uses master.
interface regfile_dump_if;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    modport slave (
        input  start, abort, first_reg, last_reg, data_readReg, out_ready,
        output ctrl_readReg, out_data, out_index, out_valid, out_last, busy, done
    );

    modport master (
        output start, abort, first_reg, last_reg, data_readReg, out_ready,
        input  ctrl_readReg, out_data, out_index, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks a (possibly wrapping) range of register indices, reads each through a combinational
// register-file port and emits one valid/ready beat per register, then pulses done.
module regfile_dump #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic          clock,
    input  logic          ctrl_reset_n,
    regfile_dump_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_idx;
    logic [4:0]  r_end_idx;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_index;
    logic        r_out_valid;
    logic        r_out_last;

    logic        w_skip;
    logic        w_at_end;
    logic        w_last;
    logic        w_beat;

    assign w_skip   = SKIP_ZERO && (r_idx == 5'd0);
    assign w_at_end = (r_idx == r_end_idx);
    // With index 0 suppressed, a range ending at 0 really ends at 31.
    assign w_last   = w_at_end || (SKIP_ZERO && (r_end_idx == 5'd0) && (r_idx == 5'd31));
    assign w_beat   = r_out_valid && bus.out_ready;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every comb output gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (w_skip) begin
                    w_next = w_at_end ? FINISH : FETCH;
                end else begin
                    w_next = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (w_beat) begin
                    w_next = r_out_last ? FINISH : FETCH;
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_idx       <= 5'd0;
            r_end_idx   <= 5'd0;
            r_out_data  <= 32'd0;
            r_out_index <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_idx     <= bus.first_reg;
                        r_end_idx <= bus.last_reg;
                    end
                end
                FETCH: begin
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (w_skip) begin
                        r_idx <= r_idx + 5'd1;
                    end else begin
                        r_out_data  <= bus.data_readReg;
                        r_out_index <= r_idx;
                        r_out_last  <= w_last;
                        r_out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (w_beat) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (!r_out_last) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The read address is only driven while fetching; done is withheld if abort lands in FINISH.
    always_comb begin
        bus.ctrl_readReg = 5'd0;
        bus.done         = 1'b0;
        bus.busy         = (r_state != IDLE);
        case (r_state)
            FETCH:   bus.ctrl_readReg = r_idx;
            FINISH:  bus.done         = !bus.abort;
            default: begin
            end
        endcase
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: one instance with SKIP_ZERO=0, one with SKIP_ZERO=1,
// sharing clock and reset; a negedge monitor pops expected beats as the DUTs emit them.
module tb_regfile_dump;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_dump_if if0 ();
    regfile_dump_if if1 ();

    regfile_dump #(.SKIP_ZERO(1'b0)) dut0 (.clock(clk), .ctrl_reset_n(rst_n), .bus(if0));
    regfile_dump #(.SKIP_ZERO(1'b1)) dut1 (.clock(clk), .ctrl_reset_n(rst_n), .bus(if1));

    logic       st  [2];
    logic       ab  [2];
    logic       rdy [2];
    logic [4:0] fr  [2];
    logic [4:0] lr  [2];

    assign if0.start     = st[0];
    assign if0.abort     = ab[0];
    assign if0.out_ready = rdy[0];
    assign if0.first_reg = fr[0];
    assign if0.last_reg  = lr[0];
    assign if1.start     = st[1];
    assign if1.abort     = ab[1];
    assign if1.out_ready = rdy[1];
    assign if1.first_reg = fr[1];
    assign if1.last_reg  = lr[1];

    // Register file model: r[i] = i + 7, so r3/r4/r5 read 0xA/0xB/0xC.
    function automatic logic [31:0] rf_val(input logic [4:0] idx);
        return 32'(idx) + 32'd7;
    endfunction

    assign if0.data_readReg = rf_val(if0.ctrl_readReg);
    assign if1.data_readReg = rf_val(if1.ctrl_readReg);

    logic [31:0] m_data  [2];
    logic [4:0]  m_index [2];
    logic [4:0]  m_rd    [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        m_busy  [2];
    logic        m_done  [2];

    assign m_data[0]  = if0.out_data;
    assign m_index[0] = if0.out_index;
    assign m_rd[0]    = if0.ctrl_readReg;
    assign m_valid[0] = if0.out_valid;
    assign m_last[0]  = if0.out_last;
    assign m_busy[0]  = if0.busy;
    assign m_done[0]  = if0.done;
    assign m_data[1]  = if1.out_data;
    assign m_index[1] = if1.out_index;
    assign m_rd[1]    = if1.ctrl_readReg;
    assign m_valid[1] = if1.out_valid;
    assign m_last[1]  = if1.out_last;
    assign m_busy[1]  = if1.busy;
    assign m_done[1]  = if1.done;

    beat_t q0[$];
    beat_t q1[$];

    int    done_cnt  [2];
    int    done_snap [2];
    int    done_cyc  [2];
    int    last_cyc  [2];
    logic  stalled   [2];
    beat_t stall_b   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int s, input logic [4:0] idx, input logic last);
        beat_t b;
        b.idx  = idx;
        b.data = rf_val(idx);
        b.last = last;
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic mon_step(input int s);
        beat_t cur;
        beat_t e;
        cur.idx  = m_index[s];
        cur.data = m_data[s];
        cur.last = m_last[s];
        if (!rst_n) begin
            stalled[s] = 1'b0;
        end else begin
            if (stalled[s]) begin
                check($sformatf("stall_valid%0d", s), 32'(m_valid[s]), 32'd1);
                check($sformatf("stall_hold%0d", s), 32'(cur), 32'(stall_b[s]));
            end
            if (m_valid[s] && rdy[s]) begin
                if (qsize(s) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat%0d: got index %0d expected no beat", s, cur.idx);
                end else begin
                    e = (s == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("beat%0d_index", s), 32'(cur.idx), 32'(e.idx));
                    check($sformatf("beat%0d_data", s), cur.data, e.data);
                    check($sformatf("beat%0d_last", s), 32'(cur.last), 32'(e.last));
                end
                if (cur.last) last_cyc[s] = cyc;
            end
            if (m_done[s]) begin
                done_cnt[s]++;
                done_cyc[s] = cyc;
            end
            if (!m_busy[s] || m_valid[s]) begin
                check($sformatf("readreg_quiet%0d", s), 32'(m_rd[s]), 32'd0);
            end
            stalled[s] = m_valid[s] && !rdy[s] && !ab[s];
            stall_b[s] = cur;
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) mon_step(s);
    end

    task automatic chk_zero(input int s, input string name);
        check({name, "_valid"}, 32'(m_valid[s]), 32'd0);
        check({name, "_last"},  32'(m_last[s]),  32'd0);
        check({name, "_data"},  m_data[s],       32'd0);
        check({name, "_index"}, 32'(m_index[s]), 32'd0);
        check({name, "_busy"},  32'(m_busy[s]),  32'd0);
        check({name, "_done"},  32'(m_done[s]),  32'd0);
        check({name, "_rdreg"}, 32'(m_rd[s]),    32'd0);
    endtask

    task automatic start_dump(input int s, input logic [4:0] first, input logic [4:0] last);
        @(posedge clk);
        #1;
        done_snap[s] = done_cnt[s];
        st[s] = 1'b1;
        fr[s] = first;
        lr[s] = last;
        @(posedge clk);
        #1;
        st[s] = 1'b0;
        fr[s] = 5'd17;
        lr[s] = 5'd9;
    endtask

    task automatic wait_valid(input int s, input string name);
        int n = 0;
        @(negedge clk);
        while (!m_valid[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid[s]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: out_valid still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic wait_idle(input int s, input int exp_done, input bit timing, input string name);
        int n = 0;
        int idle_cyc;
        @(negedge clk);
        while (m_busy[s] && n < 300) begin
            @(negedge clk);
            n++;
        end
        idle_cyc = cyc;
        #1;
        if (m_busy[s]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
        end
        check({name, "_done_count"}, 32'(done_cnt[s] - done_snap[s]), 32'(exp_done));
        check({name, "_drained"}, 32'(qsize(s)), 32'd0);
        if (timing) begin
            check({name, "_done_lat"}, 32'(done_cyc[s] - last_cyc[s]), 32'd1);
            check({name, "_idle_lat"}, 32'(idle_cyc - done_cyc[s]), 32'd1);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            st[s] = 1'b0; ab[s] = 1'b0; rdy[s] = 1'b1; fr[s] = 5'd0; lr[s] = 5'd0;
            done_cnt[s] = 0; done_snap[s] = 0; done_cyc[s] = 0; last_cyc[s] = 0;
            stalled[s] = 1'b0; stall_b[s] = '0;
        end
        rst_n = 1'b0;
        #12;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Basic range 3..5 with the downstream always ready.
        push_exp(0, 5'd3, 1'b0);
        push_exp(0, 5'd4, 1'b0);
        push_exp(0, 5'd5, 1'b1);
        start_dump(0, 5'd3, 5'd5);
        wait_idle(0, 1, 1'b1, "t1_basic");

        // Wrapping range 30..1, index 0 included.
        push_exp(0, 5'd30, 1'b0);
        push_exp(0, 5'd31, 1'b0);
        push_exp(0, 5'd0,  1'b0);
        push_exp(0, 5'd1,  1'b1);
        start_dump(0, 5'd30, 5'd1);
        wait_idle(0, 1, 1'b1, "t2_wrap");

        // SKIP_ZERO instance: 0..2 emits 1,2; {0} emits nothing; 30..0 ends on 31.
        push_exp(1, 5'd1, 1'b0);
        push_exp(1, 5'd2, 1'b1);
        start_dump(1, 5'd0, 5'd2);
        wait_idle(1, 1, 1'b1, "t3_skip");
        start_dump(1, 5'd0, 5'd0);
        wait_idle(1, 1, 1'b0, "t4_zero_only");
        push_exp(1, 5'd30, 1'b0);
        push_exp(1, 5'd31, 1'b1);
        start_dump(1, 5'd30, 5'd0);
        wait_idle(1, 1, 1'b1, "t5_skip_end");

        // Single beat at index 7 held by out_ready=0; a start pulse while busy is ignored.
        rdy[0] = 1'b0;
        push_exp(0, 5'd7, 1'b1);
        start_dump(0, 5'd7, 5'd7);
        wait_valid(0, "t6_valid");
        @(posedge clk); #1;
        st[0] = 1'b1; fr[0] = 5'd1; lr[0] = 5'd3;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        wait_idle(0, 1, 1'b1, "t6_stall");

        // Range 2..9, handshake 2 and 3 by hand, abort while index 4 is stalled.
        rdy[0] = 1'b0;
        push_exp(0, 5'd2, 1'b0);
        push_exp(0, 5'd3, 1'b0);
        start_dump(0, 5'd2, 5'd9);
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, "t7_valid");
            if (m_index[0] == 5'd4) begin
                @(posedge clk); #1;
                ab[0] = 1'b1;
                @(posedge clk); #1;
                ab[0] = 1'b0;
                break;
            end
            @(posedge clk); #1;
            rdy[0] = 1'b1;
            @(posedge clk); #1;
            rdy[0] = 1'b0;
        end
        @(negedge clk);
        check("t7_abort_valid", 32'(m_valid[0]), 32'd0);
        check("t7_abort_last",  32'(m_last[0]),  32'd0);
        check("t7_abort_busy",  32'(m_busy[0]),  32'd0);
        wait_idle(0, 0, 1'b0, "t7_abort");

        rdy[0] = 1'b1;
        push_exp(0, 5'd2, 1'b0);
        push_exp(0, 5'd3, 1'b0);
        push_exp(0, 5'd4, 1'b1);
        start_dump(0, 5'd2, 5'd4);
        wait_idle(0, 1, 1'b1, "t8_after_abort");

        // Asynchronous reset mid-dump, then a start on the first edge after release.
        rdy[0] = 1'b0;
        start_dump(0, 5'd10, 5'd20);
        wait_valid(0, "t9_valid");
        @(posedge clk); #1;
        st[0] = 1'b1; fr[0] = 5'd0; lr[0] = 5'd1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "t9_async0");
        chk_zero(1, "t9_async1");
        #2;
        done_snap[0] = done_cnt[0];
        rdy[0] = 1'b1;
        push_exp(0, 5'd5, 1'b0);
        push_exp(0, 5'd6, 1'b1);
        fr[0] = 5'd5;
        lr[0] = 5'd6;
        st[0] = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_idle(0, 1, 1'b1, "t10_post_reset");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
